// File: rtl/brg_hcc_out_req_arbiter.sv
// Shares one manycore endpoint request port among num_req_p requesters: arbitration, outstanding limits, response routing, drain.
// Define BRG_HCC_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default build is round robin.
module brg_hcc_out_req_arbiter #(
  parameter int num_req_p      = 2,
  parameter int packet_width_p = 32,
  parameter int data_width_p   = 32,
  parameter int max_out_p      = 8,
  parameter int lg_req_lp      = $clog2(num_req_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p-1:0]                req_v_i,
  input  logic [num_req_p*packet_width_p-1:0] req_packet_i,
  output logic [num_req_p-1:0]                req_yumi_o,
  output logic                                out_v_o,
  output logic [packet_width_p-1:0]           out_packet_o,
  input  logic                                out_ready_i,
  input  logic                                returned_v_i,
  input  logic [data_width_p-1:0]             returned_data_i,
  input  logic [4:0]                          returned_reg_id_i,
  input  logic [1:0]                          returned_pkt_type_i,
  output logic                                returned_yumi_o,
  output logic [num_req_p-1:0]                resp_v_o,
  output logic [data_width_p-1:0]             resp_data_o,
  output logic [4:0]                          resp_reg_id_o,
  output logic [1:0]                          resp_pkt_type_o,
  input  logic [num_req_p-1:0]                resp_yumi_i,
  input  logic                                quiesce_i,
  output logic                                quiesced_o
);

  localparam int CW = $clog2(max_out_p + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_QUIESCED} state_e;

  state_e                      r_state, w_state_nxt;
  logic                        r_valid;
  logic [packet_width_p-1:0]   r_packet;
  logic [lg_req_lp-1:0]        r_owner;
  logic [CW-1:0]               r_cnt     [num_req_p];
  logic [CW-1:0]               w_cnt_nxt [num_req_p];
  logic                        w_cnt_zero_nxt;
  logic                        w_issue, w_free, w_found, w_valid_nxt;
  logic [num_req_p-1:0]        w_elig, w_inc, w_dec;
  logic [lg_req_lp-1:0]        w_idx, w_grant_id, w_resp_owner;
  logic [packet_width_p-1:0]   w_grant_pkt;
  logic                        w_unused;

  assign out_v_o      = r_valid & out_ready_i;
  assign out_packet_o = r_packet;
  assign w_issue      = out_v_o;
  assign w_free       = ~r_valid | w_issue;
  assign quiesced_o   = (r_state == ST_QUIESCED);

  // Response routing: owner taken from the top reg_id bits, payload passes straight through.
  assign w_resp_owner    = returned_reg_id_i[4 -: lg_req_lp];
  assign resp_data_o     = returned_data_i;
  assign resp_reg_id_o   = returned_reg_id_i;
  assign resp_pkt_type_o = returned_pkt_type_i;
  assign returned_yumi_o = |(resp_v_o & resp_yumi_i);
  assign w_unused        = ^returned_reg_id_i;

  always_comb begin
    resp_v_o = '0;
    for (int unsigned r = 0; r < num_req_p; r++)
      resp_v_o[r] = returned_v_i && (w_resp_owner == lg_req_lp'(r));
  end

  // A packet still sitting in the output register is counted against its owner's limit,
  // otherwise back-to-back grants could push the counter past max_out_p.
  always_comb begin
    w_elig = '0;
    for (int unsigned r = 0; r < num_req_p; r++)
      w_elig[r] = req_v_i[r] && w_free && (r_state == ST_RUN) &&
                  ((int'(r_cnt[r]) + int'(r_valid && (r_owner == lg_req_lp'(r)))) < max_out_p);
  end

`ifndef BRG_HCC_ARB_FIXED_PRIO_EN
  logic [lg_req_lp-1:0] r_last;

  always_ff @(posedge clk_i) begin
    if (reset_i)      r_last <= lg_req_lp'(num_req_p - 1);
    else if (w_found) r_last <= w_grant_id;
  end
`endif

  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    w_idx      = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
`ifdef BRG_HCC_ARB_FIXED_PRIO_EN
      w_idx = lg_req_lp'(i);
`else
      w_idx = r_last + lg_req_lp'(i + 1);
`endif
      if (!w_found && w_elig[w_idx]) begin
        w_found    = 1'b1;
        w_grant_id = w_idx;
      end
    end
  end

  assign req_yumi_o = w_found ? (num_req_p'(1) << w_grant_id) : '0;

  always_comb begin
    w_grant_pkt = '0;
    for (int unsigned r = 0; r < num_req_p; r++)
      if (w_grant_id == lg_req_lp'(r))
        w_grant_pkt = req_packet_i[r*packet_width_p +: packet_width_p];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid  <= 1'b0;
      r_packet <= '0;
      r_owner  <= '0;
    end else if (w_found) begin
      r_valid  <= 1'b1;
      r_packet <= w_grant_pkt;
      r_owner  <= w_grant_id;
    end else if (w_issue) begin
      r_valid  <= 1'b0;
    end
  end

  always_comb begin
    w_inc          = '0;
    w_dec          = '0;
    w_cnt_zero_nxt = 1'b1;
    for (int unsigned r = 0; r < num_req_p; r++) begin
      w_inc[r]     = w_issue && (r_owner == lg_req_lp'(r));
      w_dec[r]     = returned_yumi_o && (w_resp_owner == lg_req_lp'(r));
      w_cnt_nxt[r] = r_cnt[r];
      if (w_inc[r] && !w_dec[r])      w_cnt_nxt[r] = r_cnt[r] + CW'(1);
      else if (w_dec[r] && !w_inc[r]) w_cnt_nxt[r] = r_cnt[r] - CW'(1);
      if (w_cnt_nxt[r] != '0) w_cnt_zero_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned r = 0; r < num_req_p; r++) r_cnt[r] <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Drain completes on next-cycle values so the register emptying and the last response count together.
  assign w_valid_nxt = w_found | (r_valid & ~w_issue);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:      if (quiesce_i) w_state_nxt = ST_DRAIN;
      ST_DRAIN:    if (!quiesce_i) w_state_nxt = ST_RUN;
                   else if (!w_valid_nxt && w_cnt_zero_nxt) w_state_nxt = ST_QUIESCED;
      ST_QUIESCED: if (!quiesce_i) w_state_nxt = ST_RUN;
      default:     w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_RUN;
    else         r_state <= w_state_nxt;
  end

`ifndef SYNTHESIS
  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(returned_yumi_o && (r_cnt[w_resp_owner] == '0)));
  a_no_resp_quiesced: assert property (@(posedge clk_i) disable iff (reset_i)
    !(returned_v_i && (r_state == ST_QUIESCED)));
`endif

endmodule

// File: tb/tb_brg_hcc_out_req_arbiter.sv
// Randomized scoreboard bench for brg_hcc_out_req_arbiter against an outstanding-count reference model.
module tb_brg_hcc_out_req_arbiter;
  localparam int NR   = 2;
  localparam int PW   = 16;
  localparam int DW   = 32;
  localparam int MAXO = 8;
  localparam int LG   = $clog2(NR);

  logic               clk = 1'b0;
  logic               reset_i = 1'b1;
  logic [NR-1:0]      req_v_i = '0;
  logic [NR*PW-1:0]   req_packet_i = '0;
  logic [NR-1:0]      req_yumi_o;
  logic               out_v_o;
  logic [PW-1:0]      out_packet_o;
  logic               out_ready_i = 1'b0;
  logic               returned_v_i = 1'b0;
  logic [DW-1:0]      returned_data_i = '0;
  logic [4:0]         returned_reg_id_i = '0;
  logic [1:0]         returned_pkt_type_i = '0;
  logic               returned_yumi_o;
  logic [NR-1:0]      resp_v_o;
  logic [DW-1:0]      resp_data_o;
  logic [4:0]         resp_reg_id_o;
  logic [1:0]         resp_pkt_type_o;
  logic [NR-1:0]      resp_yumi_i = '0;
  logic               quiesce_i = 1'b0;
  logic               quiesced_o;

  always #5 clk = ~clk;

  brg_hcc_out_req_arbiter #(
    .num_req_p(NR), .packet_width_p(PW), .data_width_p(DW), .max_out_p(MAXO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_packet_i(req_packet_i), .req_yumi_o(req_yumi_o),
    .out_v_o(out_v_o), .out_packet_o(out_packet_o), .out_ready_i(out_ready_i),
    .returned_v_i(returned_v_i), .returned_data_i(returned_data_i),
    .returned_reg_id_i(returned_reg_id_i), .returned_pkt_type_i(returned_pkt_type_i),
    .returned_yumi_o(returned_yumi_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_reg_id_o(resp_reg_id_o),
    .resp_pkt_type_o(resp_pkt_type_o), .resp_yumi_i(resp_yumi_i),
    .quiesce_i(quiesce_i), .quiesced_o(quiesced_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [PW-1:0] exp_q[$];

  // Reference model: outst = granted but not yet answered, issued = left the register but not answered.
  int outst [NR];
  int issued[NR];
  bit hold;
  int hold_own;
  int last;
  int mode;            // 0 run, 1 drain, 2 quiesced

  int            k_req, k_ready, k_resp;
  logic [NR-1:0] k_mask;
  logic          k_q;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      outst[r]  = 0;
      issued[r] = 0;
    end
    hold = 0; hold_own = 0; last = NR - 1; mode = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_i = 1'b1; req_v_i = '0; out_ready_i = 1'b0; returned_v_i = 1'b0;
    resp_yumi_i = '0; quiesce_i = 1'b0; k_q = 1'b0;
    @(posedge clk); #1;
    reset_i = 1'b0;
    model_reset();
    #1;
    chk("rst_req_yumi", req_yumi_o, 0);
    chk("rst_out_v", out_v_o, 0);
    chk("rst_out_packet", out_packet_o, 0);
    chk("rst_returned_yumi", returned_yumi_o, 0);
    chk("rst_resp_v", resp_v_o, 0);
    chk("rst_quiesced", quiesced_o, 0);
  endtask

  task automatic step();
    logic [NR-1:0]    rv, yi, yumi_e, respv_e;
    logic [NR*PW-1:0] pk;
    logic             rdy, rsp, ov_e, free, ry_e, all0;
    logic [4:0]       rid;
    logic [DW-1:0]    rd;
    logic [1:0]       rt;
    int               rr, g, s, c;
    @(posedge clk); #1;
    rv = '0;
    pk = '0;
    for (int r = 0; r < NR; r++) begin
      if (k_mask[r] && ($urandom_range(99) < k_req)) rv[r] = 1'b1;
      pk[r*PW +: PW] = PW'($urandom);
    end
    rdy = ($urandom_range(99) < k_ready);
    rsp = 1'b0;
    rr  = 0;
    if (mode != 2 && ($urandom_range(99) < k_resp)) begin
      s = $urandom_range(NR - 1);
      for (int i = 0; i < NR; i++) begin
        c = (s + i) % NR;
        if (!rsp && issued[c] > 0) begin rsp = 1'b1; rr = c; end
      end
    end
    rid = 5'($urandom);
    rid[4 -: LG] = rr[LG-1:0];
    rd  = $urandom;
    rt  = 2'($urandom);
    yi  = NR'($urandom);
    req_v_i = rv; req_packet_i = pk; out_ready_i = rdy;
    returned_v_i = rsp; returned_data_i = rd; returned_reg_id_i = rid;
    returned_pkt_type_i = rt; resp_yumi_i = yi; quiesce_i = k_q;
    #1;
    ov_e = hold && rdy;
    free = !hold || ov_e;
    g = -1;
    if (mode == 0 && free) begin
      for (int i = 0; i < NR; i++) begin
`ifdef BRG_HCC_ARB_FIXED_PRIO_EN
        c = i;
`else
        c = (last + 1 + i) % NR;
`endif
        if (g < 0 && rv[c] && outst[c] < MAXO) g = c;
      end
    end
    yumi_e = '0;
    if (g >= 0) yumi_e[g] = 1'b1;
    respv_e = '0;
    if (rsp) respv_e[rr] = 1'b1;
    ry_e = rsp && yi[rr];
    chk("req_yumi", req_yumi_o, yumi_e);
    chk("out_v", out_v_o, ov_e);
    chk("resp_v", resp_v_o, respv_e);
    chk("returned_yumi", returned_yumi_o, ry_e);
    chk("quiesced", quiesced_o, (mode == 2));
    if (rsp) begin
      chk("resp_data", resp_data_o, rd);
      chk("resp_reg_id", resp_reg_id_o, rid);
      chk("resp_pkt_type", resp_pkt_type_o, rt);
    end
    if (g >= 0) exp_q.push_back(pk[g*PW +: PW]);
    if (ov_e) begin issued[hold_own]++; hold = 0; end
    if (ry_e) begin issued[rr]--; outst[rr]--; end
    if (g >= 0) begin hold = 1; hold_own = g; outst[g]++; last = g; end
    all0 = 1'b1;
    for (int r = 0; r < NR; r++) if (outst[r] != 0) all0 = 1'b0;
    case (mode)
      0: if (k_q) mode = 1;
      1: if (!k_q) mode = 0; else if (all0) mode = 2;
      default: if (!k_q) mode = 0;
    endcase
  endtask

  task automatic run(input int n, input logic [NR-1:0] m, input int rq, input int rdy,
                     input int rs, input logic q);
    k_mask = m; k_req = rq; k_ready = rdy; k_resp = rs; k_q = q;
    for (int i = 0; i < n; i++) step();
  endtask

  // Scoreboard monitor: every issued packet must match the oldest granted one.
  initial begin
    logic [PW-1:0] e;
    forever begin
      @(negedge clk);
      if (out_v_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL issue_unexpected: got packet %0h expected none at %0t", out_packet_o, $time);
        end else begin
          e = exp_q.pop_front();
          chk("issue_packet", out_packet_o, e);
        end
      end
    end
  end

  initial begin
    model_reset();
    k_q = 1'b0;
    do_reset();
    run(6,  2'b11, 100, 100, 0,   1'b0);   // both requesting, ready held high
    run(40, 2'b11, 50,  100, 60,  1'b0);
    run(40, 2'b11, 70,  30,  40,  1'b0);   // frequent back-pressure
    run(25, 2'b11, 80,  60,  30,  1'b0);
    do_reset();                             // reset with traffic in flight
    run(12, 2'b01, 100, 100, 0,   1'b0);   // r0 reaches its outstanding limit
    run(3,  2'b11, 100, 100, 0,   1'b0);
    run(6,  2'b01, 100, 100, 100, 1'b0);
    run(60, 2'b11, 60,  70,  40,  1'b1);   // drain to quiesced
    run(10, 2'b11, 80,  90,  30,  1'b0);
    k_mask = 2'b11; k_req = 60; k_ready = 70; k_resp = 45;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 3) k_q = !k_q;
      step();
    end
    run(30, 2'b11, 0, 100, 100, 1'b0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
